// File: rtl/ads1292_pkg.sv
// Shared constants, state encoding and byte helpers for the ADS1292 filtered-sample packet framer.
package ads1292_pkg;

  localparam int PKT_LEN = 7;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

  localparam logic [2:0] IDX_SYNC0 = 3'd0;
  localparam logic [2:0] IDX_SYNC1 = 3'd1;
  localparam logic [2:0] IDX_SEQ   = 3'd2;
  localparam logic [2:0] IDX_D2    = 3'd3;
  localparam logic [2:0] IDX_D1    = 3'd4;
  localparam logic [2:0] IDX_D0    = 3'd5;
  localparam logic [2:0] IDX_CHK   = 3'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Modulo-256 sum of sequence number and the three data bytes; sync bytes excluded.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] seq, input logic [23:0] sample);
    pkt_checksum = seq + sample[23:16] + sample[15:8] + sample[7:0];
  endfunction

  function automatic logic [7:0] pkt_byte(
    input logic [2:0]  idx,
    input logic [7:0]  sync0,
    input logic [7:0]  sync1,
    input logic [7:0]  seq,
    input logic [23:0] sample,
    input logic [7:0]  chk
  );
    case (idx)
      IDX_SYNC0: pkt_byte = sync0;
      IDX_SYNC1: pkt_byte = sync1;
      IDX_SEQ:   pkt_byte = seq;
      IDX_D2:    pkt_byte = sample[23:16];
      IDX_D1:    pkt_byte = sample[15:8];
      IDX_D0:    pkt_byte = sample[7:0];
      IDX_CHK:   pkt_byte = chk;
      default:   pkt_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ads1292_packet_tx.sv
// Frames one 24-bit filtered ECG sample per valid/ack handshake into a 7-byte
// packet (sync, sync, seq, data MSB-first, checksum) on a valid/ready byte stream.
module ads1292_packet_tx
  import ads1292_pkg::*;
#(
  parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1 = SYNC1_DEFAULT
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [23:0] i_ADS1292_FILTERED_DATA,
  input  logic        i_ADS1292_FILTERED_DATA_VALID,
  output logic        o_ADS1292_FILTERED_DATA_ACK,
  input  logic        i_ENABLE,
  output logic [7:0]  o_UART_DATA,
  output logic        o_UART_DATA_VALID,
  input  logic        i_UART_READY,
  output logic        o_BUSY,
  output logic [7:0]  o_SEQ
);

  state_t      state_r, state_nxt_s;
  logic [2:0]  idx_r, idx_nxt_s;
  logic [23:0] sample_r, sample_nxt_s;
  logic [7:0]  chk_r, chk_nxt_s;
  logic [7:0]  seq_r, seq_nxt_s;
  logic        ack_r, ack_nxt_s;
  logic [7:0]  data_r, data_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        busy_r, busy_nxt_s;

  // State and output registers, cleared synchronously by i_RST
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      sample_r <= 24'h000000;
      chk_r    <= 8'h00;
      seq_r    <= 8'h00;
      ack_r    <= 1'b0;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      sample_r <= sample_nxt_s;
      chk_r    <= chk_nxt_s;
      seq_r    <= seq_nxt_s;
      ack_r    <= ack_nxt_s;
      data_r   <= data_nxt_s;
      valid_r  <= valid_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    sample_nxt_s = sample_r;
    chk_nxt_s    = chk_r;
    seq_nxt_s    = seq_r;
    ack_nxt_s    = 1'b0;
    data_nxt_s   = data_r;
    valid_nxt_s  = valid_r;

    case (state_r)
      ST_IDLE: begin
        valid_nxt_s = 1'b0;
        if (i_ENABLE && i_ADS1292_FILTERED_DATA_VALID) begin
          // Checksum is frozen at latch time so later input changes cannot corrupt the packet
          sample_nxt_s = i_ADS1292_FILTERED_DATA;
          chk_nxt_s    = pkt_checksum(seq_r, i_ADS1292_FILTERED_DATA);
          ack_nxt_s    = 1'b1;
          idx_nxt_s    = IDX_SYNC0;
          data_nxt_s   = SYNC0;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (valid_r && i_UART_READY) begin
          if (idx_r == IDX_CHK) begin
            idx_nxt_s   = 3'd0;
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + 3'd1;
            data_nxt_s  = pkt_byte(idx_r + 3'd1, SYNC0, SYNC1, seq_r, sample_r, chk_r);
            valid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        valid_nxt_s = 1'b0;
        seq_nxt_s   = seq_r + 8'd1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        valid_nxt_s = 1'b0;
        idx_nxt_s   = 3'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  assign o_ADS1292_FILTERED_DATA_ACK = ack_r;
  assign o_UART_DATA                 = data_r;
  assign o_UART_DATA_VALID           = valid_r;
  assign o_BUSY                      = busy_r;
  assign o_SEQ                       = seq_r;

endmodule
